mem_rd_seq: RTL and testbench

Read-side sequencer that drives the read ports of the memory system (`mem_sys`). It fetches `len` words, one bit per cycle, from a selected x bank (small, 10-bit address) and a selected w bank (large, 20-bit address) in lockstep. It assembles each pair of words and hands them to the compute datapath over a valid/ready stream. It is the initiator for the request/address/select/read-data interface on which the memories act as responders.

---
 rtl/mem_rd_seq.sv | 167 ++++++++++++++++
 tb/tb_mem_rd_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_seq.sv
// mem_rd_seq: read-side sequencer for the x/w memory banks.
// Fetches len words bit-serially from an x bank and a w bank in lockstep,
// assembles each pair of words, and offers it downstream on a valid/ready
// stream. Every output is registered; the FSM lives in one clocked block.
module mem_rd_seq #(
    parameter int WORD_W  = 8,
    parameter int XADDR_W = 10,
    parameter int WADDR_W = 20,
    parameter int LEN_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [XADDR_W-1:0] base_x,
    input  logic [WADDR_W-1:0] base_w,
    input  logic [1:0]         bank_x,
    input  logic [1:0]         bank_w,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    output logic               done,
    output logic               read_rq_x,
    output logic               read_rq_w,
    output logic               write_rq_x,
    output logic               write_rq_w,
    output logic [XADDR_W-1:0] rw_address_x,
    output logic [WADDR_W-1:0] rw_address,
    output logic [1:0]         sel_x,
    output logic [1:0]         sel_w,
    input  logic               read_data_x,
    input  logic               read_data_w,
    output logic [WORD_W-1:0]  x_word,
    output logic [WORD_W-1:0]  w_word,
    output logic               out_valid,
    input  logic               out_ready
);

    // Stream handshake: a word pair transfers on a cycle where out_valid and
    // out_ready are both high; while out_valid is high without out_ready the
    // words are held unchanged and no memory reads are issued.

    localparam int BI_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [BI_W-1:0]    bi_q;
    logic [LEN_W-1:0]   wi_q;
    logic [LEN_W-1:0]   len_q;
    logic [XADDR_W-1:0] addr_x_q;
    logic [WADDR_W-1:0] addr_w_q;
    logic [1:0]         sel_x_q;
    logic [1:0]         sel_w_q;
    logic [WORD_W-1:0]  x_word_q;
    logic [WORD_W-1:0]  w_word_q;
    logic               busy_q;
    logic               done_q;
    logic               read_rq_q;
    logic               out_valid_q;

    logic bit_last_d;
    logic word_last_d;

    // Last-bit / last-word decodes used by the FSM.
    always_comb begin
        bit_last_d  = (bi_q == BI_W'(WORD_W - 1));
        word_last_d = (wi_q == (len_q - LEN_W'(1)));
    end

    // Sequencer FSM. Addresses advance by one per fetched bit and are
    // contiguous across words, so base + wi*WORD_W + bi is kept incrementally
    // and wraps naturally at the address width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bi_q        <= '0;
            wi_q        <= '0;
            len_q       <= '0;
            addr_x_q    <= '0;
            addr_w_q    <= '0;
            sel_x_q     <= '0;
            sel_w_q     <= '0;
            x_word_q    <= '0;
            w_word_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            read_rq_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sel_x_q <= bank_x;
                        sel_w_q <= bank_w;
                        len_q   <= len;
                        wi_q    <= '0;
                        bi_q    <= '0;
                        busy_q  <= 1'b1;
                        if (len == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_FETCH;
                            read_rq_q <= 1'b1;
                            addr_x_q  <= base_x;
                            addr_w_q  <= base_w;
                        end
                    end
                end
                S_FETCH: begin
                    x_word_q[bi_q] <= read_data_x;
                    w_word_q[bi_q] <= read_data_w;
                    if (bit_last_d) begin
                        bi_q        <= '0;
                        read_rq_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_HOLD;
                    end else begin
                        bi_q     <= bi_q + BI_W'(1);
                        addr_x_q <= addr_x_q + XADDR_W'(1);
                        addr_w_q <= addr_w_q + WADDR_W'(1);
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (word_last_d) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            wi_q      <= wi_q + LEN_W'(1);
                            state_q   <= S_FETCH;
                            read_rq_q <= 1'b1;
                            addr_x_q  <= addr_x_q + XADDR_W'(1);
                            addr_w_q  <= addr_w_q + WADDR_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign read_rq_x    = read_rq_q;
    assign read_rq_w    = read_rq_q;
    assign write_rq_x   = 1'b0;
    assign write_rq_w   = 1'b0;
    assign rw_address_x = addr_x_q;
    assign rw_address   = addr_w_q;
    assign sel_x        = sel_x_q;
    assign sel_w        = sel_w_q;
    assign x_word       = x_word_q;
    assign w_word       = w_word_q;
    assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_mem_rd_seq.sv
// tb_mem_rd_seq: directed bench for mem_rd_seq with a bit-addressed memory
// model and a cycle-by-cycle expected schedule.
module tb_mem_rd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  base_x;
  logic [19:0] base_w;
  logic [1:0]  bank_x;
  logic [1:0]  bank_w;
  logic [9:0]  len;
  logic        busy;
  logic        done;
  logic        read_rq_x;
  logic        read_rq_w;
  logic        write_rq_x;
  logic        write_rq_w;
  logic [9:0]  rw_address_x;
  logic [19:0] rw_address;
  logic [1:0]  sel_x;
  logic [1:0]  sel_w;
  logic        read_data_x;
  logic        read_data_w;
  logic [7:0]  x_word;
  logic [7:0]  w_word;
  logic        out_valid;
  logic        out_ready;

  int n_checks;
  int n_fail;
  int cyc;
  logic [7:0] last_x_word;

  logic x_mem [0:1023];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (got running, need finished)");
    $fatal(1, "timeout");
  end

  // ---------------- memory model ----------------
  function automatic logic w_bit(input logic [19:0] a);
    return a[1] ^ a[4] ^ a[9] ^ a[19];
  endfunction

  assign read_data_x = x_mem[rw_address_x];
  assign read_data_w = w_bit(rw_address);

  mem_rd_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .base_x(base_x), .base_w(base_w), .bank_x(bank_x), .bank_w(bank_w), .len(len),
    .busy(busy), .done(done),
    .read_rq_x(read_rq_x), .read_rq_w(read_rq_w),
    .write_rq_x(write_rq_x), .write_rq_w(write_rq_w),
    .rw_address_x(rw_address_x), .rw_address(rw_address),
    .sel_x(sel_x), .sel_w(sel_w),
    .read_data_x(read_data_x), .read_data_w(read_data_w),
    .x_word(x_word), .w_word(w_word),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, need 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " rq_x"}, 32'(read_rq_x), 0);
    check({tag, " rq_w"}, 32'(read_rq_w), 0);
    check({tag, " valid"}, 32'(out_valid), 0);
    check({tag, " wr"}, 32'({write_rq_x, write_rq_w}), 0);
  endtask

  // ---------------- driver + expected schedule ----------------
  // Start is sampled at edge 0; cyc counts negedges after that edge.
  task automatic run_xfer(input logic [9:0] bx, input logic [19:0] bw,
                          input logic [1:0] kx, input logic [1:0] kw,
                          input logic [9:0] n, input int stall0, input bit glitch);
    logic [9:0]  ea_x;
    logic [19:0] ea_w;
    logic [7:0]  ex_x;
    logic [7:0]  ex_w;
    logic [19:0] hold_x;
    logic [19:0] hold_w;
    @(negedge clk);
    base_x = bx; base_w = bw; bank_x = kx; bank_w = kw; len = n;
    start = 1'b1;
    hold_x = 20'(rw_address_x);
    hold_w = rw_address;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    if (n == 0) begin
      tick();
      check("len0 done", 32'(done), 1);
      check("len0 busy", 32'(busy), 1);
      check("len0 rq", 32'({read_rq_x, read_rq_w}), 0);
      check("len0 addr_x hold", 32'(rw_address_x), hold_x);
      check("len0 addr_w hold", 32'(rw_address), hold_w);
      tick();
      check("len0 done end", 32'(done), 0);
      check("len0 busy end", 32'(busy), 0);
      return;
    end
    for (int w = 0; w < int'(n); w++) begin
      for (int b = 0; b < 8; b++) begin
        tick();
        ea_x = bx + 10'(w * 8 + b);
        ea_w = bw + 20'(w * 8 + b);
        ex_x[b] = x_mem[ea_x];
        ex_w[b] = w_bit(ea_w);
        check("fetch rq_x", 32'(read_rq_x), 1);
        check("fetch rq_w", 32'(read_rq_w), 1);
        check("fetch wr", 32'({write_rq_x, write_rq_w}), 0);
        check("fetch addr_x", 32'(rw_address_x), 32'(ea_x));
        check("fetch addr_w", 32'(rw_address), 32'(ea_w));
        check("fetch valid", 32'(out_valid), 0);
        check("fetch busy", 32'(busy), 1);
        check("fetch done", 32'(done), 0);
        check("sel_x", 32'(sel_x), 32'(kx));
        check("sel_w", 32'(sel_w), 32'(kw));
        if (glitch && w == 0 && b == 2) begin
          start = 1'b1;
          base_x = bx ^ 10'h155;
          base_w = bw ^ 20'h0F0F0;
          bank_x = ~kx;
          len = n + 10'd3;
        end else if (glitch && w == 0 && b == 3) begin
          start = 1'b0;
        end
      end
      for (int s = 0; s <= ((w == 0) ? stall0 : 0); s++) begin
        tick();
        check("hold valid", 32'(out_valid), 1);
        check("hold rq", 32'({read_rq_x, read_rq_w}), 0);
        check("hold x_word", 32'(x_word), 32'(ex_x));
        check("hold w_word", 32'(w_word), 32'(ex_w));
        check("hold sel", 32'({sel_x, sel_w}), 32'({kx, kw}));
        check("hold done", 32'(done), 0);
        out_ready = (s == ((w == 0) ? stall0 : 0));
      end
      out_ready = 1'b1;
      last_x_word = ex_x;
    end
    tick();
    check("done pulse", 32'(done), 1);
    check("done cycle", 32'(cyc), 32'(int'(n) * 9 + 1 + stall0));
    check("done busy", 32'(busy), 1);
    check("done valid", 32'(out_valid), 0);
    check("done rq", 32'({read_rq_x, read_rq_w}), 0);
    tick();
    check("after done", 32'(done), 0);
    check("after busy", 32'(busy), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    base_x = '0; base_w = '0; bank_x = '0; bank_w = '0; len = '0;
    for (int i = 0; i < 1024; i++) x_mem[i] = ((i % 3) == 0) ^ ((i % 7) == 2);
    // hand-loaded word: bits 0x10..0x17 = 1,0,1,1,0,0,0,1 -> 8'h8D
    x_mem[10'h010] = 1; x_mem[10'h011] = 0; x_mem[10'h012] = 1; x_mem[10'h013] = 1;
    x_mem[10'h014] = 0; x_mem[10'h015] = 0; x_mem[10'h016] = 0; x_mem[10'h017] = 1;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset addr_x", 32'(rw_address_x), 0);
    check("reset addr_w", 32'(rw_address), 0);
    check("reset sel", 32'({sel_x, sel_w}), 0);
    check("reset words", 32'({x_word, w_word}), 0);
    rst = 1'b0;

    // single word
    run_xfer(10'h010, 20'h00100, 2'd0, 2'd3, 10'd1, 0, 1'b0);
    check("single x_word 8D", 32'(last_x_word), 32'h8D);
    check("single x_word held", 32'(x_word), 32'h8D);

    // multi-word
    run_xfer(10'h040, 20'h12345, 2'd2, 2'd1, 10'd3, 0, 1'b0);

    // backpressure on word 0
    run_xfer(10'h0A5, 20'h0ABCD, 2'd1, 2'd2, 10'd2, 5, 1'b0);

    // wrap
    run_xfer(10'h3FC, 20'hFFFFC, 2'd3, 2'd0, 10'd1, 0, 1'b0);

    // length 0
    run_xfer(10'h123, 20'h54321, 2'd1, 2'd1, 10'd0, 0, 1'b0);

    // ignored start during FETCH
    run_xfer(10'h200, 20'h40000, 2'd2, 2'd2, 10'd2, 0, 1'b1);

    // asynchronous reset mid-FETCH
    @(negedge clk);
    base_x = 10'h080; base_w = 20'h00800; bank_x = 2'd3; bank_w = 2'd3; len = 10'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-reset rq", 32'(read_rq_x), 1);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("async rst");
    check("async rst addr", 32'({rw_address_x, rw_address}), 0);
    check("async rst sel", 32'({sel_x, sel_w}), 0);
    check("async rst words", 32'({x_word, w_word}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("no done after rst", 32'(done), 0);
    end
    run_xfer(10'h081, 20'h00801, 2'd1, 2'd3, 10'd2, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
